// File: rtl/tile_cfg_pkg.sv
// Shared types and width helpers for the tile configuration loader.
package tile_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadConn,
    StLoadClb,
    StCheck,
    StDone,
    StErr
  } state_e;

  // Ceiling log2 with a floor of one bit, so single-value counters stay legal.
  function automatic int unsigned clog2_fn(input int unsigned value);
    int unsigned width;
    int unsigned span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span << 1;
      width = width + 1;
    end
    return (width == 0) ? 1 : width;
  endfunction

  function automatic int unsigned max_fn(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tile_cfg_loader_if.sv
// Word-level configuration port: start pulse plus valid/ready data handshake.
interface tile_cfg_loader_if #(
  parameter int unsigned CFG_W = 8
);
  logic             start;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_valid;
  logic             cfg_ready;

  modport master (output start, output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input start, input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/cfg_serializer.sv
// Single-word shift buffer: load a word, emit it LSB-first, flush on demand.
module cfg_serializer
  import tile_cfg_pkg::*;
#(
  parameter int unsigned CFG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CFG_W-1:0] load_data,
  input  logic             shift,
  input  logic             flush,
  output logic             scan_bit,
  output logic             empty
);

  localparam int unsigned CntW = clog2_fn(CFG_W + 1);

  logic [CFG_W-1:0] word_q, word_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (flush) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (load) begin
      word_d = load_data;
      cnt_d  = CntW'(CFG_W);
    end else if (shift && (cnt_q != '0)) begin
      word_d = word_q >> 1;
      cnt_d  = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign scan_bit = word_q[0];
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/tile_cfg_loader.sv
// Tile configuration sequencer: streams words onto the conn then clb scan chains
// and verifies a trailing XOR-fold check word.
module tile_cfg_loader
  import tile_cfg_pkg::*;
#(
  parameter int unsigned CFG_W          = 8,
  parameter int unsigned CONN_CHAIN_LEN = 64,
  parameter int unsigned CLB_CHAIN_LEN  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  tile_cfg_loader_if.slave    cfg,
  output logic                conn_scan_in,
  output logic                conn_scan_en,
  output logic                clb_scan_in,
  output logic                clb_scan_en,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int unsigned   CntW     = clog2_fn(max_fn(CONN_CHAIN_LEN, CLB_CHAIN_LEN) + 1);
  localparam logic [CntW-1:0] ConnLast = CntW'(CONN_CHAIN_LEN - 1);
  localparam logic [CntW-1:0] ClbLast  = CntW'(CLB_CHAIN_LEN - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  chain_cnt_q, chain_cnt_d;
  logic [CFG_W-1:0] checksum_q, checksum_d;

  logic ser_load, ser_shift, ser_flush, ser_bit, ser_empty;
  logic accept;

  cfg_serializer #(
    .CFG_W (CFG_W)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (cfg.cfg_data),
    .shift     (ser_shift),
    .flush     (ser_flush),
    .scan_bit  (ser_bit),
    .empty     (ser_empty)
  );

  // Ready depends on registered state only, never on cfg_valid.
  assign cfg.cfg_ready = ((state_q == StLoadConn) || (state_q == StLoadClb) ||
                          (state_q == StCheck)) && ser_empty;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  assign busy  = (state_q == StLoadConn) || (state_q == StLoadClb) || (state_q == StCheck);
  assign done  = (state_q == StDone);
  assign error = (state_q == StErr);

  always_comb begin
    state_d      = state_q;
    chain_cnt_d  = chain_cnt_q;
    checksum_d   = checksum_q;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;
    ser_flush    = 1'b0;
    conn_scan_in = 1'b0;
    conn_scan_en = 1'b0;
    clb_scan_in  = 1'b0;
    clb_scan_en  = 1'b0;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (cfg.start) begin
          state_d     = StLoadConn;
          chain_cnt_d = '0;
          checksum_d  = '0;
          ser_flush   = 1'b1;
        end
      end
      StLoadConn: begin
        if (accept) begin
          ser_load   = 1'b1;
          checksum_d = checksum_q ^ cfg.cfg_data;
        end else if (!ser_empty) begin
          conn_scan_en = 1'b1;
          conn_scan_in = ser_bit;
          // Last chain bit: drop whatever padding is left in the word.
          if (chain_cnt_q == ConnLast) begin
            ser_flush   = 1'b1;
            chain_cnt_d = '0;
            state_d     = StLoadClb;
          end else begin
            ser_shift   = 1'b1;
            chain_cnt_d = chain_cnt_q + CntW'(1);
          end
        end
      end
      StLoadClb: begin
        if (accept) begin
          ser_load   = 1'b1;
          checksum_d = checksum_q ^ cfg.cfg_data;
        end else if (!ser_empty) begin
          clb_scan_en = 1'b1;
          clb_scan_in = ser_bit;
          if (chain_cnt_q == ClbLast) begin
            ser_flush   = 1'b1;
            chain_cnt_d = '0;
            state_d     = StCheck;
          end else begin
            ser_shift   = 1'b1;
            chain_cnt_d = chain_cnt_q + CntW'(1);
          end
        end
      end
      StCheck: begin
        if (accept) begin
          state_d = (cfg.cfg_data == checksum_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      chain_cnt_q <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      chain_cnt_q <= chain_cnt_d;
      checksum_q  <= checksum_d;
    end
  end

endmodule

// File: tb/tb_tile_cfg_loader.sv
// Directed bench for tile_cfg_loader with a 10-bit conn chain and 5-bit clb chain.
module tb_tile_cfg_loader;

  localparam int unsigned CFG_W    = 8;
  localparam int unsigned CONN_LEN = 10;
  localparam int unsigned CLB_LEN  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_cfg_loader_if #(.CFG_W(CFG_W)) cfg_bus ();

  logic conn_scan_in, conn_scan_en, clb_scan_in, clb_scan_en, busy, done, error;

  tile_cfg_loader #(
    .CFG_W          (CFG_W),
    .CONN_CHAIN_LEN (CONN_LEN),
    .CLB_CHAIN_LEN  (CLB_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (cfg_bus),
    .conn_scan_in (conn_scan_in),
    .conn_scan_en (conn_scan_en),
    .clb_scan_in  (clb_scan_in),
    .clb_scan_en  (clb_scan_en),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  int checks   = 0;
  int failures = 0;

  bit conn_bits[$];
  bit clb_bits[$];
  int accepts    = 0;
  int overlaps   = 0;
  int idle_dirty = 0;

  logic [7:0] bp_words [4] = '{8'hA5, 8'h03, 8'h1E, 8'hB8};

  // Observe the DUT mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (conn_scan_en) conn_bits.push_back(conn_scan_in);
    if (clb_scan_en) clb_bits.push_back(clb_scan_in);
    if (cfg_bus.cfg_valid && cfg_bus.cfg_ready) accepts++;
    if (cfg_bus.cfg_ready && (conn_scan_en || clb_scan_en)) overlaps++;
    if ((!conn_scan_en && conn_scan_in) || (!clb_scan_en && clb_scan_in) ||
        (conn_scan_en && clb_scan_en)) idle_dirty++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_bus.start = 1'b1;
    tick();
    cfg_bus.start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input int gap);
    bit ok;
    ok = 1'b0;
    cfg_bus.cfg_data  = d;
    cfg_bus.cfg_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (cfg_bus.cfg_ready) ok = 1'b1;
    end
    tick();
    cfg_bus.cfg_valid = 1'b0;
    check("word_accept", 32'(ok), 32'd1);
    repeat (gap) tick();
  endtask

  task automatic wait_finish(input string pfx);
    for (int n = 0; n < 200 && !(done || error); n++) @(negedge clk);
    check({pfx, "_finish"}, 32'(done || error), 32'd1);
    tick();
  endtask

  task automatic check_bits(input string pfx, input int conn_base, input int clb_base);
    logic [31:0] v;
    v = '0;
    for (int i = conn_base; i < conn_bits.size() && i < conn_base + 32; i++)
      v[i - conn_base] = conn_bits[i];
    check({pfx, "_conn_len"}, 32'(conn_bits.size() - conn_base), 32'd10);
    check({pfx, "_conn_bits"}, v, 32'h0000_03A5);
    v = '0;
    for (int i = clb_base; i < clb_bits.size() && i < clb_base + 32; i++)
      v[i - clb_base] = clb_bits[i];
    check({pfx, "_clb_len"}, 32'(clb_bits.size() - clb_base), 32'd5);
    check({pfx, "_clb_bits"}, v, 32'h0000_001E);
  endtask

  task automatic run_stream(input string pfx, input logic [7:0] chk, input int gap,
                            input bit mid_start);
    int cb, lb, ov, id;
    cb = conn_bits.size();
    lb = clb_bits.size();
    ov = overlaps;
    id = idle_dirty;
    pulse_start();
    send_word(8'hA5, gap);
    send_word(8'h03, gap);
    send_word(8'h1E, gap);
    if (mid_start) begin
      check({pfx, "_busy_in_clb"}, 32'(busy), 32'd1);
      pulse_start();
    end
    send_word(chk, gap);
    wait_finish(pfx);
    check_bits(pfx, cb, lb);
    check({pfx, "_ready_vs_shift"}, 32'(overlaps - ov), 32'd0);
    check({pfx, "_idle_chain_quiet"}, 32'(idle_dirty - id), 32'd0);
  endtask

  initial begin
    int cb, lb, ov, acc0, idx;
    cfg_bus.start     = 1'b0;
    cfg_bus.cfg_data  = '0;
    cfg_bus.cfg_valid = 1'b0;

    // Reset state, with cfg_valid high to show nothing is consumed in IDLE.
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs",
          {24'd0, conn_scan_in, conn_scan_en, clb_scan_in, clb_scan_en, busy, done, error,
           cfg_bus.cfg_ready}, 32'd0);
    rst_n = 1'b1;
    acc0 = accepts;
    cfg_bus.cfg_valid = 1'b1;
    repeat (3) tick();
    cfg_bus.cfg_valid = 1'b0;
    check("idle_no_consume", 32'(accepts - acc0), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Nominal load.
    run_stream("nominal", 8'hB8, 0, 1'b0);
    check("nominal_done", 32'(done), 32'd1);
    check("nominal_error", 32'(error), 32'd0);

    // Idle cycles between words must not change the scan sequences.
    run_stream("gaps", 8'hB8, 3, 1'b0);
    check("gaps_done", 32'(done), 32'd1);

    // Bad check word, then restart.
    run_stream("bad", 8'hB9, 0, 1'b0);
    check("bad_error", 32'(error), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_busy", 32'(busy), 32'd0);
    pulse_start();
    check("restart_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_error", 32'(error), 32'd0);

    // Backpressure: cfg_valid held high throughout, continuing from the restart.
    cb   = conn_bits.size();
    lb   = clb_bits.size();
    ov   = overlaps;
    acc0 = accepts;
    idx  = 0;
    cfg_bus.cfg_data  = bp_words[0];
    cfg_bus.cfg_valid = 1'b1;
    for (int n = 0; n < 200 && idx < 4; n++) begin
      @(negedge clk);
      if (cfg_bus.cfg_ready) begin
        tick();
        idx++;
        if (idx < 4) cfg_bus.cfg_data = bp_words[idx];
      end
    end
    repeat (20) tick();
    check("bp_words_consumed", 32'(accepts - acc0), 32'd4);
    check("bp_done", 32'(done), 32'd1);
    check("bp_ready_after_done", 32'(cfg_bus.cfg_ready), 32'd0);
    check_bits("bp", cb, lb);
    check("bp_ready_vs_shift", 32'(overlaps - ov), 32'd0);
    cfg_bus.cfg_valid = 1'b0;

    // Reset on the 4th conn shift cycle.
    pulse_start();
    send_word(8'hA5, 0);
    repeat (3) tick();
    check("rst_pre_shift_en", 32'(conn_scan_en), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_outputs",
          {24'd0, conn_scan_in, conn_scan_en, clb_scan_in, clb_scan_en, busy, done, error,
           cfg_bus.cfg_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    run_stream("reload", 8'hB8, 0, 1'b0);
    check("reload_done", 32'(done), 32'd1);

    // start pulsed during LOAD_CLB is ignored.
    run_stream("busy_start", 8'hB8, 0, 1'b1);
    check("busy_start_done", 32'(done), 32'd1);
    check("busy_start_error", 32'(error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
